// File: rtl/led_code_blinker_if.sv
// Blink-code request channel: one code (pulse count + colour) per valid/ready handshake.
interface led_code_blinker_if #(
    parameter int unsigned CW = 4
);
    logic          code_valid;
    logic [CW-1:0] code;
    logic [1:0]    code_color;
    logic          code_ready;

    modport master (
        output code_valid,
        output code,
        output code_color,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code,
        input  code_color,
        output code_ready
    );
endinterface

// File: rtl/led_code_blinker.sv
// LED code blinker: forwards the flasher heartbeat to the LED pins and, on request,
// overrides it with N pulses of a chosen colour, repeated, then hands the LEDs back.
module led_code_blinker #(
    parameter int unsigned TICK_DIV  = 2660000,
    parameter int unsigned ON_TICKS  = 3,
    parameter int unsigned OFF_TICKS = 3,
    parameter int unsigned GAP_TICKS = 15,
    parameter int unsigned REPEAT    = 2,
    parameter int unsigned CW        = 4
) (
    input  logic                     Clk,
    input  logic                     sys_rst,
    input  logic                     hb_red,
    input  logic                     hb_green,
    input  logic                     code_flush,
    led_code_blinker_if.slave        req,
    output logic                     red,
    output logic                     green,
    output logic                     busy
);

    localparam int unsigned PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_A   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAX_LEN = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
    localparam int unsigned PH_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned RP_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [PS_W-1:0]   ps_q;
    logic [PH_W-1:0]   ph_q;
    logic [CW-1:0]     pulses_q;
    logic [RP_W-1:0]   reps_q;
    logic [CW-1:0]     act_code_q;
    logic [1:0]        act_color_q;
    logic [CW-1:0]     pend_code_q;
    logic [1:0]        pend_color_q;
    logic              pend_full_q;
    logic              red_q;
    logic              green_q;
    logic              busy_q;

    logic              tick_c;
    logic              phase_end_c;
    logic              accept_nz_c;

    assign req.code_ready = !pend_full_q && !code_flush;
    assign tick_c         = (ps_q == PS_W'(TICK_DIV - 1));
    assign phase_end_c    = tick_c && (ph_q == '0);
    assign accept_nz_c    = req.code_valid && req.code_ready && (req.code != '0);

    assign red   = red_q;
    assign green = green_q;
    assign busy  = busy_q;

    // Sequencer: prescaler, phase timing, pulse/repeat counters and the request slots.
    always_ff @(posedge Clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= ST_IDLE;
            ps_q         <= '0;
            ph_q         <= '0;
            pulses_q     <= '0;
            reps_q       <= '0;
            act_code_q   <= '0;
            act_color_q  <= '0;
            pend_code_q  <= '0;
            pend_color_q <= '0;
            pend_full_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ps_q <= tick_c ? '0 : ps_q + PS_W'(1);
            if (tick_c && (ph_q != '0)) begin
                ph_q <= ph_q - PH_W'(1);
            end

            if (code_flush) begin
                state_q     <= ST_IDLE;
                pend_full_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept_nz_c) begin
                            act_code_q  <= req.code;
                            act_color_q <= req.code_color;
                            pulses_q    <= req.code;
                            reps_q      <= RP_W'(REPEAT - 1);
                            ps_q        <= '0;
                            ph_q        <= PH_W'(ON_TICKS - 1);
                            state_q     <= ST_ON;
                            busy_q      <= 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (phase_end_c) begin
                            ph_q    <= PH_W'(OFF_TICKS - 1);
                            state_q <= ST_OFF;
                        end
                    end
                    ST_OFF: begin
                        if (phase_end_c) begin
                            if (pulses_q > CW'(1)) begin
                                pulses_q <= pulses_q - CW'(1);
                                ph_q     <= PH_W'(ON_TICKS - 1);
                                state_q  <= ST_ON;
                            end else begin
                                ph_q    <= PH_W'(GAP_TICKS - 1);
                                state_q <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (phase_end_c) begin
                            if (reps_q != '0) begin
                                reps_q   <= reps_q - RP_W'(1);
                                pulses_q <= act_code_q;
                                ph_q     <= PH_W'(ON_TICKS - 1);
                                state_q  <= ST_ON;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Queued code takes over; a request arriving with the slot
                        // empty starts directly so it cannot strand in the pending slot.
                        if (pend_full_q) begin
                            act_code_q  <= pend_code_q;
                            act_color_q <= pend_color_q;
                            pulses_q    <= pend_code_q;
                            pend_full_q <= 1'b0;
                            reps_q      <= RP_W'(REPEAT - 1);
                            ps_q        <= '0;
                            ph_q        <= PH_W'(ON_TICKS - 1);
                            state_q     <= ST_ON;
                        end else if (accept_nz_c) begin
                            act_code_q  <= req.code;
                            act_color_q <= req.code_color;
                            pulses_q    <= req.code;
                            reps_q      <= RP_W'(REPEAT - 1);
                            ps_q        <= '0;
                            ph_q        <= PH_W'(ON_TICKS - 1);
                            state_q     <= ST_ON;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase

                if (accept_nz_c && ((state_q == ST_ON) || (state_q == ST_OFF) ||
                                    (state_q == ST_GAP))) begin
                    pend_code_q  <= req.code;
                    pend_color_q <= req.code_color;
                    pend_full_q  <= 1'b1;
                end
            end
        end
    end

    // LED drive: heartbeat in IDLE, code colour in ON, dark otherwise (one-cycle latency).
    always_ff @(posedge Clk or negedge sys_rst) begin
        if (!sys_rst) begin
            red_q   <= 1'b1;
            green_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    red_q   <= hb_red;
                    green_q <= hb_green;
                end
                ST_ON: begin
                    red_q   <= !act_color_q[0];
                    green_q <= !act_color_q[1];
                end
                default: begin
                    red_q   <= 1'b1;
                    green_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_code_blinker.sv
// Scoreboard bench for led_code_blinker: expected LED/busy samples are queued when a
// request is accepted and compared every falling edge; empty queue means heartbeat passthrough.
module tb_led_code_blinker;

    localparam int unsigned TD   = 4;
    localparam int unsigned ONT  = 2;
    localparam int unsigned OFFT = 2;
    localparam int unsigned GAPT = 4;
    localparam int unsigned REP  = 2;
    localparam int unsigned CW   = 4;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } exp_t;

    logic Clk        = 1'b0;
    logic sys_rst    = 1'b1;
    logic hb_red     = 1'b1;
    logic hb_green   = 1'b1;
    logic code_flush = 1'b0;
    logic red;
    logic green;
    logic busy;

    led_code_blinker_if #(.CW(CW)) req_if ();

    led_code_blinker #(
        .TICK_DIV  (TD),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .GAP_TICKS (GAPT),
        .REPEAT    (REP),
        .CW        (CW)
    ) dut (
        .Clk        (Clk),
        .sys_rst    (sys_rst),
        .hb_red     (hb_red),
        .hb_green   (hb_green),
        .code_flush (code_flush),
        .req        (req_if),
        .red        (red),
        .green      (green),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic hb_r_edge = 1'b1;
    logic hb_g_edge = 1'b1;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Heartbeat as seen by the DUT at each rising edge, plus an edge counter.
    always @(posedge Clk) begin
        cyc       <= cyc + 1;
        hb_r_edge <= hb_red;
        hb_g_edge <= hb_green;
    end

    // Compare one sample per falling edge against the scoreboard or the heartbeat.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("red",   32'(red),   32'(mon_e.r));
                chk("green", 32'(green), 32'(mon_e.g));
                chk("busy",  32'(busy),  32'(mon_e.b));
            end else begin
                chk("pt_red",   32'(red),   32'(hb_r_edge));
                chk("pt_green", 32'(green), 32'(hb_g_edge));
                chk("pt_busy",  32'(busy),  32'(0));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
        hb_red   = 1'($urandom_range(0, 1));
        hb_green = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic r, input logic g, input logic b);
        exp_t e;
        e.r = r;
        e.g = g;
        e.b = b;
        exp_q.push_back(e);
    endtask

    // Full pattern for one code: REP x (code x (ON, OFF) + GAP), busy throughout.
    task automatic push_seq(input int code, input logic [1:0] col);
        for (int r = 0; r < int'(REP); r++) begin
            for (int p = 0; p < code; p++) begin
                for (int k = 0; k < int'(ONT * TD); k++)  push(!col[0], !col[1], 1'b1);
                for (int k = 0; k < int'(OFFT * TD); k++) push(1'b1, 1'b1, 1'b1);
            end
            for (int k = 0; k < int'(GAPT * TD); k++) push(1'b1, 1'b1, 1'b1);
        end
    endtask

    // DONE cycle: dark; busy stays high only if another code follows.
    task automatic push_done(input logic chain);
        push(1'b1, 1'b1, chain);
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [1:0] col, input string tag);
        req_if.code_valid = 1'b1;
        req_if.code       = c;
        req_if.code_color = col;
        chk({tag, "_ready"}, 32'(req_if.code_ready), 32'(1));
        step();
        req_if.code_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    int s_cyc;
    int n_wait;

    initial begin
        req_if.code_valid = 1'b0;
        req_if.code       = '0;
        req_if.code_color = '0;

        // Reset values
        #1 sys_rst = 1'b0;
        #1;
        chk("rst_red",   32'(red),   32'(1));
        chk("rst_green", 32'(green), 32'(1));
        chk("rst_busy",  32'(busy),  32'(0));
        chk("rst_ready", 32'(req_if.code_ready), 32'(1));
        repeat (2) @(posedge Clk);
        #1 sys_rst = 1'b1;
        step();
        mon_en = 1'b1;
        idle(10);

        // Single code: 3 red pulses, repeated, then passthrough
        offer(4'd3, 2'b01, "a");
        push(hb_r_edge, hb_g_edge, 1'b1);
        push_seq(3, 2'b01);
        push_done(1'b0);
        drain(400);
        idle(8);

        // Zero code is consumed and dropped
        offer(4'd0, 2'b01, "zero");
        idle(10);

        // Chain: A playing, B queued, C stalls until A's DONE frees the slot
        offer(4'd3, 2'b01, "ca");
        s_cyc = cyc;
        push(hb_r_edge, hb_g_edge, 1'b1);
        push_seq(3, 2'b01);
        offer(4'd1, 2'b10, "cb");
        push_done(1'b1);
        push_seq(1, 2'b10);
        chk("ready_full", 32'(req_if.code_ready), 32'(0));
        req_if.code_valid = 1'b1;
        req_if.code       = 4'd2;
        req_if.code_color = 2'b11;
        n_wait = 0;
        while (!req_if.code_ready && n_wait < 300) begin
            step();
            n_wait++;
        end
        step();
        req_if.code_valid = 1'b0;
        chk("c_accept_cycle", 32'(cyc), 32'(s_cyc + 130));
        push_done(1'b1);
        push_seq(2, 2'b11);
        push_done(1'b0);
        drain(600);
        idle(8);

        // Flush mid-ON with pending full; request in the flush cycle is ignored
        offer(4'd3, 2'b01, "fa");
        push(hb_r_edge, hb_g_edge, 1'b1);
        push_seq(3, 2'b01);
        offer(4'd1, 2'b10, "fb");
        req_if.code_valid = 1'b1;
        req_if.code       = 4'd2;
        req_if.code_color = 2'b10;
        step();
        step();
        code_flush = 1'b1;
        #1;
        chk("ready_flush", 32'(req_if.code_ready), 32'(0));
        step();
        code_flush        = 1'b0;
        req_if.code_valid = 1'b0;
        exp_q.delete();
        push(1'b0, 1'b1, 1'b0);
        #1;
        chk("ready_after_flush", 32'(req_if.code_ready), 32'(1));
        idle(20);

        // Asynchronous reset in the middle of a GAP
        offer(4'd1, 2'b11, "ra");
        push(hb_r_edge, hb_g_edge, 1'b1);
        push_seq(1, 2'b11);
        push_done(1'b0);
        idle(20);
        sys_rst = 1'b0;
        mon_en  = 1'b0;
        #1;
        chk("mid_rst_red",   32'(red),   32'(1));
        chk("mid_rst_green", 32'(green), 32'(1));
        chk("mid_rst_busy",  32'(busy),  32'(0));
        chk("mid_rst_ready", 32'(req_if.code_ready), 32'(1));
        exp_q.delete();
        @(negedge Clk);
        sys_rst = 1'b1;
        step();
        mon_en = 1'b1;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
